// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32IM execute stage: CSR read-modify-write,
// trap entry for illegal instructions and interrupts, mret, and 64-bit counters.
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_1100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [11:0] csr_addr_i,
  input  logic        csr_read_i,
  input  logic        csr_write_i,
  input  logic        csr_op_inv_i,
  input  logic        csr_no_cal_i,
  input  logic [31:0] csr_operand_i,
  input  logic        csr_src_zero_i,
  input  logic        mret_i,
  input  logic        instr_illegal_i,
  input  logic        instret_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  output logic [31:0] csr_rdata_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        csr_illegal_o
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] CAUSE_EXT     = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER   = 32'h8000_0007;
  localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_meie_q, mie_meie_d;
  logic        mie_mtie_q, mie_mtie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  // While rst is high the outputs already reflect reset values, so every
  // consumer reads these views rather than the raw flops.
  logic        mstatus_mie_v, mstatus_mpie_v, mie_meie_v, mie_mtie_v;
  logic [31:0] mtvec_v, mscratch_v, mepc_v, mcause_v;
  logic [63:0] mcycle_v, minstret_v;

  assign mstatus_mie_v  = rst ? 1'b0 : mstatus_mie_q;
  assign mstatus_mpie_v = rst ? 1'b0 : mstatus_mpie_q;
  assign mie_meie_v     = rst ? 1'b0 : mie_meie_q;
  assign mie_mtie_v     = rst ? 1'b0 : mie_mtie_q;
  assign mtvec_v        = rst ? (MTVEC_RESET & ALIGN_MASK) : mtvec_q;
  assign mscratch_v     = rst ? 32'h0 : mscratch_q;
  assign mepc_v         = rst ? 32'h0 : mepc_q;
  assign mcause_v       = rst ? 32'h0 : mcause_q;
  assign mcycle_v       = rst ? 64'h0 : mcycle_q;
  assign minstret_v     = rst ? 64'h0 : minstret_q;

  logic [31:0] mstatus_val, mie_val, mip_val;

  assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_v, 3'b0, mstatus_mie_v, 3'b0};
  assign mie_val     = {20'b0, mie_meie_v, 3'b0, mie_mtie_v, 7'b0};
  assign mip_val     = {20'b0, irq_ext_i, 3'b0, irq_timer_i, 7'b0};

  logic [31:0] old_val;
  logic        addr_mapped;

  always_comb begin
    old_val     = 32'h0;
    addr_mapped = 1'b1;
    case (csr_addr_i)
      ADDR_MSTATUS:   old_val = mstatus_val;
      ADDR_MISA:      old_val = MISA_VALUE;
      ADDR_MIE:       old_val = mie_val;
      ADDR_MTVEC:     old_val = mtvec_v;
      ADDR_MSCRATCH:  old_val = mscratch_v;
      ADDR_MEPC:      old_val = mepc_v;
      ADDR_MCAUSE:    old_val = mcause_v;
      ADDR_MIP:       old_val = mip_val;
      ADDR_MCYCLE:    old_val = mcycle_v[31:0];
      ADDR_MCYCLEH:   old_val = mcycle_v[63:32];
      ADDR_MINSTRET:  old_val = minstret_v[31:0];
      ADDR_MINSTRETH: old_val = minstret_v[63:32];
      default:        addr_mapped = 1'b0;
    endcase
  end

  assign csr_rdata_o = old_val;

  logic [31:0] new_val;
  logic        write_eff;
  logic        csr_access;

  assign new_val    = csr_no_cal_i ? csr_operand_i :
                      csr_op_inv_i ? (old_val & ~csr_operand_i) :
                                     (old_val | csr_operand_i);
  // Set/clear with a zero source is a pure read and never counts as a write.
  assign write_eff  = csr_write_i & (csr_no_cal_i | ~csr_src_zero_i);
  assign csr_access = valid_i & (csr_read_i | csr_write_i);

  assign csr_illegal_o = csr_access &
                         (~addr_mapped | (write_eff & (csr_addr_i[11:10] == 2'b11)));

  logic exc_take, irq_pend, irq_ext_sel, irq_take, mret_take, trap_take, csr_we;

  assign irq_ext_sel = mie_meie_v & irq_ext_i;
  assign irq_pend    = mstatus_mie_v & (irq_ext_sel | (mie_mtie_v & irq_timer_i));
  assign exc_take    = (valid_i & instr_illegal_i) | csr_illegal_o;
  assign irq_take    = valid_i & ~exc_take & irq_pend;
  assign trap_take   = exc_take | irq_take;
  assign mret_take   = valid_i & ~trap_take & mret_i;
  assign csr_we      = valid_i & write_eff & ~trap_take & ~mret_take;

  assign redirect_o    = trap_take | mret_take;
  assign redirect_pc_o = trap_take ? mtvec_v : mepc_v;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
    mie_mtie_d     = mie_mtie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    if (trap_take) begin
      mepc_d         = pc_i & ALIGN_MASK;
      mcause_d       = exc_take ? CAUSE_ILLEGAL : (irq_ext_sel ? CAUSE_EXT : CAUSE_TIMER);
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_take) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (csr_we) begin
      case (csr_addr_i)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = new_val[3];
          mstatus_mpie_d = new_val[7];
        end
        ADDR_MIE: begin
          mie_meie_d = new_val[11];
          mie_mtie_d = new_val[7];
        end
        ADDR_MTVEC:    mtvec_d    = new_val & ALIGN_MASK;
        ADDR_MSCRATCH: mscratch_d = new_val;
        ADDR_MEPC:     mepc_d     = new_val & ALIGN_MASK;
        ADDR_MCAUSE:   mcause_d   = new_val;
        default: ;
      endcase
    end
  end

  logic wr_mcycle_lo, wr_mcycle_hi, wr_minstret_lo, wr_minstret_hi;
  logic mcycle_carry, minstret_carry;

  assign wr_mcycle_lo   = csr_we & (csr_addr_i == ADDR_MCYCLE);
  assign wr_mcycle_hi   = csr_we & (csr_addr_i == ADDR_MCYCLEH);
  assign wr_minstret_lo = csr_we & (csr_addr_i == ADDR_MINSTRET);
  assign wr_minstret_hi = csr_we & (csr_addr_i == ADDR_MINSTRETH);

  // A write to the low half replaces it outright, so no carry leaves it that cycle.
  assign mcycle_carry   = (&mcycle_q[31:0]) & ~wr_mcycle_lo;
  assign minstret_carry = instret_i & (&minstret_q[31:0]) & ~wr_minstret_lo;

  always_comb begin
    mcycle_d[31:0]    = wr_mcycle_lo ? new_val : (mcycle_q[31:0] + 32'd1);
    mcycle_d[63:32]   = wr_mcycle_hi ? new_val :
                        (mcycle_q[63:32] + {31'b0, mcycle_carry});
    minstret_d[31:0]  = wr_minstret_lo ? new_val :
                        (minstret_q[31:0] + {31'b0, instret_i});
    minstret_d[63:32] = wr_minstret_hi ? new_val :
                        (minstret_q[63:32] + {31'b0, minstret_carry});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mtvec_q        <= MTVEC_RESET & ALIGN_MASK;
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mcycle_q       <= 64'h0;
      minstret_q     <= 64'h0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
      mie_mtie_q     <= mie_mtie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: inputs change 1ns after the rising edge and the
// combinational outputs are sampled on the falling edge.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] pc_i;
  logic [11:0] csr_addr_i;
  logic        csr_read_i;
  logic        csr_write_i;
  logic        csr_op_inv_i;
  logic        csr_no_cal_i;
  logic [31:0] csr_operand_i;
  logic        csr_src_zero_i;
  logic        mret_i;
  logic        instr_illegal_i;
  logic        instret_i;
  logic        irq_ext_i;
  logic        irq_timer_i;
  logic [31:0] csr_rdata_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        csr_illegal_o;

  int n_checks = 0;
  int n_errors = 0;

  csr_file dut (
    .clk             (clk),
    .rst             (rst),
    .valid_i         (valid_i),
    .pc_i            (pc_i),
    .csr_addr_i      (csr_addr_i),
    .csr_read_i      (csr_read_i),
    .csr_write_i     (csr_write_i),
    .csr_op_inv_i    (csr_op_inv_i),
    .csr_no_cal_i    (csr_no_cal_i),
    .csr_operand_i   (csr_operand_i),
    .csr_src_zero_i  (csr_src_zero_i),
    .mret_i          (mret_i),
    .instr_illegal_i (instr_illegal_i),
    .instret_i       (instret_i),
    .irq_ext_i       (irq_ext_i),
    .irq_timer_i     (irq_timer_i),
    .csr_rdata_o     (csr_rdata_o),
    .redirect_o      (redirect_o),
    .redirect_pc_o   (redirect_pc_o),
    .csr_illegal_o   (csr_illegal_o)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i         = 1'b0;
    pc_i            = 32'h0;
    csr_addr_i      = 12'h0;
    csr_read_i      = 1'b0;
    csr_write_i     = 1'b0;
    csr_op_inv_i    = 1'b0;
    csr_no_cal_i    = 1'b0;
    csr_operand_i   = 32'h0;
    csr_src_zero_i  = 1'b0;
    mret_i          = 1'b0;
    instr_illegal_i = 1'b0;
  endtask

  task automatic drive_csr(input logic [11:0] a, input logic wr, input logic inv,
                           input logic nocal, input logic [31:0] op, input logic sz);
    valid_i        = 1'b1;
    csr_addr_i     = a;
    csr_read_i     = 1'b1;
    csr_write_i    = wr;
    csr_op_inv_i   = inv;
    csr_no_cal_i   = nocal;
    csr_operand_i  = op;
    csr_src_zero_i = sz;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    drive_csr(a, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check(tag, csr_rdata_o, exp);
    step();
    idle();
  endtask

  task automatic wr_chk(input string tag, input logic [11:0] a, input logic inv, input logic nocal,
                        input logic [31:0] op, input logic sz, input logic [31:0] exp_old);
    drive_csr(a, 1'b1, inv, nocal, op, sz);
    @(negedge clk);
    check(tag, csr_rdata_o, exp_old);
    step();
    idle();
  endtask

  task automatic wr_only(input logic [11:0] a, input logic [31:0] op);
    drive_csr(a, 1'b1, 1'b0, 1'b1, op, 1'b0);
    step();
    idle();
  endtask

  initial begin
    rst         = 1'b1;
    instret_i   = 1'b0;
    irq_ext_i   = 1'b0;
    irq_timer_i = 1'b0;
    idle();
    step();
    drive_csr(12'h300, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("rst_mstatus_out", csr_rdata_o, 32'h0000_1800);
    check("rst_redirect", {31'b0, redirect_o}, 32'h0);
    step();
    rst = 1'b0;
    idle();

    rd_chk("mstatus_reset", 12'h300, 32'h0000_1800);
    rd_chk("mtvec_reset",   12'h305, 32'h0000_0100);
    rd_chk("misa_value",    12'h301, 32'h4000_1100);

    // mscratch read-modify-write
    wr_chk("csrrw_old",  12'h340, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
    wr_chk("csrrs_old",  12'h340, 1'b0, 1'b0, 32'h0000_0011, 1'b0, 32'hDEAD_BEEF);
    wr_chk("csrrc_old",  12'h340, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 32'hDEAD_BEFF);
    rd_chk("mscratch_after_rc", 12'h340, 32'hDEAD_BEFE);
    wr_chk("csrrs_zero_old", 12'h340, 1'b0, 1'b0, 32'h0000_FFFF, 1'b1, 32'hDEAD_BEFE);
    rd_chk("mscratch_srczero", 12'h340, 32'hDEAD_BEFE);

    // external interrupt entry and mret
    wr_chk("set_mie_bit", 12'h300, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 32'h0000_1800);
    wr_chk("set_meie",    12'h304, 1'b0, 1'b0, 32'h0000_0800, 1'b0, 32'h0);
    irq_ext_i = 1'b1;
    @(negedge clk);
    check("irq_no_valid", {31'b0, redirect_o}, 32'h0);
    step();
    valid_i = 1'b1;
    pc_i    = 32'h0000_0080;
    @(negedge clk);
    check("irq_redirect",    {31'b0, redirect_o}, 32'h1);
    check("irq_redirect_pc", redirect_pc_o, 32'h0000_0100);
    step();
    idle();
    irq_ext_i = 1'b0;
    rd_chk("irq_mepc",    12'h341, 32'h0000_0080);
    rd_chk("irq_mcause",  12'h342, 32'h8000_000B);
    rd_chk("irq_mstatus", 12'h300, 32'h0000_1880);
    valid_i = 1'b1;
    mret_i  = 1'b1;
    @(negedge clk);
    check("mret_redirect",    {31'b0, redirect_o}, 32'h1);
    check("mret_redirect_pc", redirect_pc_o, 32'h0000_0080);
    step();
    idle();
    rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);

    // illegal instruction beats a pending timer interrupt
    wr_chk("set_mtie", 12'h304, 1'b0, 1'b0, 32'h0000_0080, 1'b0, 32'h0000_0800);
    irq_timer_i     = 1'b1;
    valid_i         = 1'b1;
    instr_illegal_i = 1'b1;
    pc_i            = 32'h0000_0044;
    @(negedge clk);
    check("exc_redirect_pc", redirect_pc_o, 32'h0000_0100);
    step();
    idle();
    irq_timer_i = 1'b0;
    rd_chk("exc_mcause",  12'h342, 32'h0000_0002);
    rd_chk("exc_mepc",    12'h341, 32'h0000_0044);
    rd_chk("exc_mstatus", 12'h300, 32'h0000_1880);

    // CSR access faults
    drive_csr(12'hC00, 1'b1, 1'b0, 1'b1, 32'h5, 1'b0);
    @(negedge clk);
    check("wr_c00_illegal",  {31'b0, csr_illegal_o}, 32'h1);
    check("wr_c00_redirect", {31'b0, redirect_o}, 32'h1);
    step();
    idle();
    drive_csr(12'h7C0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("rd_7c0_illegal", {31'b0, csr_illegal_o}, 32'h1);
    check("rd_7c0_data",    csr_rdata_o, 32'h0);
    step();
    idle();
    drive_csr(12'h340, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("rd_340_legal", {31'b0, csr_illegal_o}, 32'h0);
    step();
    idle();

    // mcycle carry into mcycleh
    wr_only(12'hB80, 32'h0);
    wr_only(12'hB00, 32'hFFFF_FFFF);
    step();
    rd_chk("mcycleh_carry", 12'hB80, 32'h1);
    rd_chk("mcycle_wrap",   12'hB00, 32'h1);

    // minstret counts instret_i only
    rd_chk("minstret_start", 12'hB02, 32'h0);
    instret_i = 1'b1;
    repeat (3) step();
    instret_i = 1'b0;
    rd_chk("minstret_plus3", 12'hB02, 32'h3);
    rd_chk("minstreth_zero", 12'hB82, 32'h0);

    // misa ignores writes, mtvec forces alignment
    wr_chk("misa_wr_old", 12'h301, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h4000_1100);
    rd_chk("misa_readonly", 12'h301, 32'h4000_1100);
    wr_chk("mtvec_wr_old", 12'h305, 1'b0, 1'b1, 32'h0000_0203, 1'b0, 32'h0000_0100);
    rd_chk("mtvec_aligned", 12'h305, 32'h0000_0200);

    // reset overrides a trap in the same cycle
    rst             = 1'b1;
    valid_i         = 1'b1;
    instr_illegal_i = 1'b1;
    pc_i            = 32'h0000_0200;
    step();
    rst = 1'b0;
    idle();
    rd_chk("rst_trap_mepc",     12'h341, 32'h0);
    rd_chk("rst_trap_mcause",   12'h342, 32'h0);
    rd_chk("rst_trap_mstatus",  12'h300, 32'h0000_1800);
    rd_chk("rst_trap_mtvec",    12'h305, 32'h0000_0100);
    rd_chk("rst_trap_mscratch", 12'h340, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
